// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: scans HUB75 row pairs (prefetch, shift, latch, display, blank) from a registered frame RAM
// Ports: clk; reset (sync, active-high); en scan enable;
//   rd_addr {row,col} / rd_data {r0,g0,b0,r1,g1,b1} frame RAM port, data valid 1 cycle after address;
//   r0,g0,b0,r1,g1,b1,sclk,lat,oe_n,row_addr registered panel outputs;
//   frame_done one-cycle pulse on the last BLANK cycle of the last row pair.
// Optional: define HUB75_BRIGHTNESS_EN to add brightness[7:0], capping the oe_n-low cycles per DISPLAY.
module hub75_scan_driver #(
    parameter  int COLS         = 64,
    parameter  int ROWS         = 32,
    parameter  int ON_CYCLES    = 256,
    parameter  int BLANK_CYCLES = 4,
    localparam int COL_W        = $clog2(COLS),
    localparam int ROW_W        = $clog2(ROWS / 2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]             brightness,
`endif
    output logic [ROW_W+COL_W-1:0] rd_addr,
    input  logic [5:0]             rd_data,
    output logic                   r0,
    output logic                   g0,
    output logic                   b0,
    output logic                   r1,
    output logic                   g1,
    output logic                   b1,
    output logic                   sclk,
    output logic                   lat,
    output logic                   oe_n,
    output logic [ROW_W-1:0]       row_addr,
    output logic                   frame_done
);
    localparam int MAX_A = 2 * COLS > ON_CYCLES ? 2 * COLS : ON_CYCLES;
    localparam int MAXL  = MAX_A > BLANK_CYCLES ? MAX_A : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAXL + 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, LATCH, DISPLAY, BLANK} state_t;

    state_t           state, ns;
    logic [CNT_W-1:0] cnt, ncnt, lim;
    logic [ROW_W-1:0] row, nrow;
    logic             last;

`ifdef HUB75_BRIGHTNESS_EN
    logic [CNT_W-1:0] bright_q;
    // brightness is taken on DISPLAY entry and held for the rest of DISPLAY
    assign lim = state == DISPLAY ? bright_q
               : CNT_W'(int'(brightness) < ON_CYCLES ? int'(brightness) : ON_CYCLES);
`else
    assign lim = CNT_W'(ON_CYCLES);
`endif

    always_comb begin
        last = 1'b0;
        case (state)
            PREFETCH: last = cnt == CNT_W'(1);
            SHIFT:    last = cnt == CNT_W'(2 * COLS - 1);
            LATCH:    last = 1'b1;
            DISPLAY:  last = cnt == CNT_W'(ON_CYCLES - 1);
            BLANK:    last = cnt == CNT_W'(BLANK_CYCLES - 1);
            default:  last = en;
        endcase
        ns   = !last ? state
             : state == IDLE || state == BLANK ? (en ? PREFETCH : IDLE)
             : state == PREFETCH ? SHIFT
             : state == SHIFT ? LATCH
             : state == LATCH ? DISPLAY : BLANK;
        ncnt = last || state == IDLE ? '0 : cnt + 1'b1;
        nrow = state == BLANK && last ? (row == ROW_W'(ROWS / 2 - 1) ? '0 : row + 1'b1) : row;
    end

    // Outputs are registered from the next-state values so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            rd_addr    <= '0;
            {r0, g0, b0, r1, g1, b1} <= '0;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= '0;
            frame_done <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
            bright_q   <= '0;
`endif
        end else begin
            state      <= ns;
            cnt        <= ncnt;
            row        <= nrow;
            sclk       <= ns == SHIFT && ncnt[0];
            lat        <= ns == LATCH;
            oe_n       <= !(ns == DISPLAY && ncnt < lim);
            frame_done <= ns == BLANK && ncnt == CNT_W'(BLANK_CYCLES - 1) && nrow == ROW_W'(ROWS / 2 - 1);
            if (state == LATCH)
                row_addr <= row;
            // column c is addressed two cycles ahead of its sclk-low phase; hold at the last column
            rd_addr    <= ns == PREFETCH ? {nrow, COL_W'(0)}
                        : ns == SHIFT && !ncnt[0] && rd_addr[COL_W-1:0] != '1 ? rd_addr + 1'b1
                        : rd_addr;
            if ((state == PREFETCH && cnt == CNT_W'(1)) || (state == SHIFT && cnt[0]))
                {r0, g0, b0, r1, g1, b1} <= rd_data;
`ifdef HUB75_BRIGHTNESS_EN
            bright_q   <= lim;
`endif
        end
    end
endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Upstream stage of the LED-panel output registers. Produces the six HUB75 colour bits (r0/g0/b0 for the upper half, r1/g1/b1 for the lower half) plus the panel control signals sclk, lat, oe_n and row_addr.
- Reads one row pair per scan from a registered frame memory, shifts it out column by column, latches it, then displays it for a fixed on-time.
- Loops over all row pairs continuously while enabled.

Parameters:
- COLS, 64, pixels per panel row; must be a power of 2.
- ROWS, 32, panel rows; ROWS/2 row pairs are scanned.
- ON_CYCLES, 256, clk cycles with oe_n low per row.
- BLANK_CYCLES, 4, clk cycles with oe_n high after display, before the next row.
- Derived: COL_W=$clog2(COLS), ROW_W=$clog2(ROWS/2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- en  input  1  scan enable
- rd_addr  output  ROW_W+COL_W  frame memory address {row, col}
- rd_data  input  6  {r0,g0,b0,r1,g1,b1}; valid 1 cycle after rd_addr (registered RAM)
- r0, g0, b0, r1, g1, b1  output  1 each  registered colour bits to panel
- sclk  output  1  panel shift clock
- lat  output  1  panel latch strobe
- oe_n  output  1  panel output enable, active low
- row_addr  output  ROW_W  row pair currently displayed
- frame_done  output  1  one-cycle pulse when the last row pair finishes BLANK

Behaviour:
- Reset (sync, active-high): state=IDLE; all colour bits=0, sclk=0, lat=0, oe_n=1, row_addr=0, rd_addr=0, frame_done=0; internal row/col counters=0.
- Reset asserted mid-operation overrides every state, including mid-shift and mid-display. The panel is blanked (oe_n=1) on the next cycle.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, PREFETCH, SHIFT, LATCH, DISPLAY, BLANK.
- IDLE: oe_n=1, sclk=0. Goes to PREFETCH when en=1.
- PREFETCH: 2 cycles. rd_addr={row,0} in the first cycle.
- SHIFT: 2 cycles per column (phase0 sclk=0, phase1 sclk=1), COLS columns, 2*COLS cycles total.
  - Let cycle P be the first PREFETCH cycle.
  - rd_addr for column c is presented at cycle P+2c.
  - Colour registers load rd_data at the end of cycle P+2c+1.
  - Column c data is stable on cycles P+2c+2 (sclk=0) and P+2c+3 (sclk=1). The rising sclk edge is therefore centred in stable data.
  - rd_addr is not advanced past column COLS-1; it holds {row,COLS-1}.
- LATCH: 1 cycle. sclk=0, lat=1, oe_n=1, row_addr<=row. Colour bits hold the last column's values.
- DISPLAY: ON_CYCLES cycles. oe_n=0, lat=0.
- BLANK: BLANK_CYCLES cycles. oe_n=1.
  - On the last BLANK cycle, row<=row+1, wrapping from ROWS/2-1 to 0.
  - frame_done=1 for exactly that one cycle, and only when the wrap occurs.
- After BLANK: PREFETCH if en=1, else IDLE.
- en deasserted mid-row: the current row completes through BLANK and no new row starts. The row counter is kept, so re-enable resumes at the next row pair.
- Row timing with defaults: 2+128+1+256+4 = 391 cycles. Frame = 16 × 391 = 6256 cycles.
- oe_n and lat are never low/high together: lat=1 only while oe_n=1.

Optional Feature:
- Macro: HUB75_BRIGHTNESS_EN.
- Defined: adds input brightness [7:0]. In DISPLAY, oe_n=0 only for the first min(brightness, ON_CYCLES) cycles, then oe_n=1 for the rest of DISPLAY. DISPLAY duration is unchanged, so the frame rate is constant. brightness is sampled once, on entry to DISPLAY. brightness=0 keeps oe_n=1 for the whole of DISPLAY.
- Undefined: no brightness port; oe_n=0 for the whole of DISPLAY.

Test Plan:
1. Reset, then en=1 with reset held for 3 cycles → all outputs at reset values throughout; PREFETCH starts the cycle after reset falls.
2. One row with a RAM model where rd_data = col[5:0] → on the k-th sclk rising edge, {r0..b1} = k-1 for k=1..64. Exactly 64 sclk pulses; lat pulses once, 1 cycle, at cycle 130 after P. oe_n low for 256 cycles, then high for 4.
3. Full frame → row_addr steps 0..15 then 0. frame_done pulses once every 6256 cycles, coincident with the wrap.
4. en dropped during SHIFT of row 5 → row 5 still latched and displayed; IDLE after BLANK, row_addr=5. Re-enable → next rd_addr row field = 6.
5. reset pulsed during DISPLAY of row 3 → oe_n=1 and row_addr=0 on the next cycle; the following scan starts at row 0.
6. HUB75_BRIGHTNESS_EN, brightness=64 → 64 cycles oe_n=0 then 192 cycles oe_n=1 within DISPLAY. brightness=0 → oe_n never low. Row length stays 391 cycles in both cases.
